// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the instruction-fetch
// requester and the data (MEM-stage) requester of a pipelined processor.
//
// Ports:
//   clk, reset                      - rising-edge clock, asynchronous active-low reset
//   if_req/if_addr                  - fetch request (held until if_done)
//   if_rdata/if_done                - fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata       - data request (load/store)
//   d_rdata/d_done                  - load data and one-cycle completion pulse
//   bus_err                         - pulses with a done whose access timed out
//   stall_f/stall_m                 - pipeline freeze while an access is outstanding
//   mem_valid/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ready   - valid/ready memory port
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              bus_err,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q;  // 1 = data won the previous arbitration
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_done_q, d_done_q, bus_err_q;
  logic [7:0]        tmo_q;

  logic busy, tmo_hit, finish, pick_d, pick_i;

  // Data wins a tie unless it won last time, so neither side can starve.
  assign pick_d  = (state_q == StIdle) && d_req && (!if_req || !last_grant_q);
  assign pick_i  = (state_q == StIdle) && if_req && !pick_d;
  assign busy    = (state_q == StBusyI) || (state_q == StBusyD);
  assign tmo_hit = busy && !mem_ready && (tmo_q == TmoLast);
  assign finish  = busy && (mem_ready || tmo_hit);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d = StBusyD;
        end else if (pick_i) begin
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        if (finish) begin
          state_d = StDone;
        end
      end
      // One dead cycle so a req dropped after sampling done is not served again.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; decoded from state so reset kills mem_valid immediately.
  always_comb begin
    mem_valid = busy;
    mem_we    = (state_q == StBusyD) && mem_we_q;
  end

  // Request latch, timeout counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      if_done_q <= finish && (state_q == StBusyI);
      d_done_q  <= finish && (state_q == StBusyD);
      bus_err_q <= tmo_hit;

      if (pick_d) begin
        mem_addr_q   <= d_addr;
        mem_we_q     <= d_we;
        mem_wdata_q  <= d_wdata;
        last_grant_q <= 1'b1;
      end else if (pick_i) begin
        mem_addr_q   <= if_addr;
        mem_we_q     <= 1'b0;
        last_grant_q <= 1'b0;
      end

      if (pick_d || pick_i) begin
        tmo_q <= '0;
      end else if (busy && !mem_ready) begin
        tmo_q <= tmo_q + 8'd1;
      end

      if (finish && (state_q == StBusyI)) begin
        if_rdata_q <= mem_ready ? mem_rdata : '0;
      end
      // A completed store leaves d_rdata alone; a timed-out access zeroes it.
      if (finish && (state_q == StBusyD) && (!mem_we_q || !mem_ready)) begin
        d_rdata_q <= mem_ready ? mem_rdata : '0;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign stall_f   = if_req && !if_done_q;
  assign stall_m   = d_req && !d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected transfers, a memory
// responder checks the port while mem_valid is high, and a monitor pops on each done.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_done, d_done, bus_err, stall_f, stall_m;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .bus_err  (bus_err),
    .stall_f  (stall_f),
    .stall_m  (stall_m),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          len;   // cycles mem_valid is expected high
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   rsp_delay = 0;   // busy cycles before ready; -1 = never
  bit   force_ready = 1'b0;
  int   run = 0;
  int   last_run = 0;
  int   if_more = 0;
  int   d_more = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] lookup(logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C22_0004;
      32'h44:  return 32'h0022_1820;
      32'h100: return 32'h1234_5678;
      default: return 32'hA5A5_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  task automatic push(bit is_d, logic [31:0] addr, bit we, logic [31:0] wdata,
                      logic [31:0] rdata, bit err, int len);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.we = we; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.len = len;
    q.push_back(e);
  endtask

  task automatic wait_drain(int budget, string name);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout_pending"}, 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Memory responder: checks the held request each valid cycle, drives ready/rdata.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (q.size() == 0) begin
          chk("valid_without_request", 64'(mem_valid), 64'd0);
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
          chk("mem_we", 64'(mem_we), 64'(q[0].we));
          if (q[0].we) chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
        end
        mem_ready = force_ready || (rsp_delay >= 0 && run == rsp_delay);
        mem_rdata = mem_ready ? lookup(mem_addr) : 32'h0BAD_F00D;
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        mem_ready = force_ready;
        mem_rdata = 32'h0BAD_F00D;
      end
    end
  end

  // Requesters: hold req until done, optionally re-issuing the same request.
  initial begin
    forever begin
      @(negedge clk);
      if (if_done) begin
        if (if_more > 0) if_more--;
        else if_req = 1'b0;
      end
      if (d_done) begin
        if (d_more > 0) d_more--;
        else d_req = 1'b0;
      end
    end
  end

  // Monitor: pops one expected transfer per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (if_done && d_done) begin
        chk("dual_done", 64'(if_done && d_done), 64'd0);
      end else if (if_done || d_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'({if_done, d_done}), 64'd0);
        end else begin
          e = q.pop_front();
          chk("done_port_is_d", 64'(d_done), 64'(e.is_d));
          chk("bus_err", 64'(bus_err), 64'(e.err));
          chk("valid_len", 64'(last_run), 64'(e.len));
          if (e.is_d) begin
            chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
            chk("stall_m_at_done", 64'(stall_m), 64'd0);
          end else begin
            chk("if_rdata", 64'(if_rdata), 64'(e.rdata));
            chk("stall_f_at_done", 64'(stall_f), 64'd0);
          end
        end
      end else if (bus_err) begin
        chk("stray_bus_err", 64'(bus_err), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_if_done", 64'(if_done), 64'd0);
    chk("rst_d_done", 64'(d_done), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: lone fetch, ready on first valid cycle
    rsp_delay = 0;
    push(0, 32'h40, 0, 32'h0, 32'h8C22_0004, 0, 1);
    if_addr = 32'h40;
    if_req  = 1'b1;
    #1;
    chk("t1_stall_f_req", 64'(stall_f), 64'd1);
    chk("t1_valid_not_yet", 64'(mem_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_valid_n1", 64'(mem_valid), 64'd1);
    chk("t1_done_not_yet", 64'(if_done), 64'd0);
    chk("t1_stall_f_busy", 64'(stall_f), 64'd1);
    @(negedge clk);
    #1;
    chk("t1_done_n2", 64'(if_done), 64'd1);
    chk("t1_valid_off", 64'(mem_valid), 64'd0);
    wait_drain(20, "t1");

    // 2: simultaneous requests, then both held for alternation
    push(1, 32'h100, 0, 32'h0, 32'h1234_5678, 0, 1);
    push(0, 32'h44, 0, 32'h0, 32'h0022_1820, 0, 1);
    d_addr = 32'h100; d_we = 1'b0; if_addr = 32'h44;
    d_req = 1'b1; if_req = 1'b1;
    wait_drain(30, "t2a");
    for (int i = 0; i < 3; i++) begin
      push(1, 32'h100, 0, 32'h0, 32'h1234_5678, 0, 1);
      push(0, 32'h44, 0, 32'h0, 32'h0022_1820, 0, 1);
    end
    d_more = 2; if_more = 2;
    d_req = 1'b1; if_req = 1'b1;
    wait_drain(60, "t2b");

    // 3: store with delayed ready; d_rdata keeps the last load value
    rsp_delay = 4;
    push(1, 32'h200, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5);
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    wait_drain(30, "t3");
    d_we = 1'b0;

    // 4: no ready -> timeout, then a normal load
    rsp_delay = -1;
    push(1, 32'h104, 0, 32'h0, 32'h0, 1, 15);
    d_addr = 32'h104;
    d_req = 1'b1;
    wait_drain(40, "t4a");
    rsp_delay = 1;
    push(1, 32'h108, 0, 32'h0, 32'hA5A5_0108, 0, 2);
    d_addr = 32'h108;
    d_req = 1'b1;
    wait_drain(30, "t4b");

    // 5: reset mid fetch, then re-arbitration with if_req still high
    rsp_delay = 10;
    push(0, 32'h80, 0, 32'h0, 32'hA5A5_0080, 0, 1);
    if_addr = 32'h80;
    if_req = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("t5_valid_before_rst", 64'(mem_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_valid_async_drop", 64'(mem_valid), 64'd0);
    chk("t5_no_done", 64'(if_done), 64'd0);
    chk("t5_if_rdata_cleared", 64'(if_rdata), 64'd0);
    q.delete();
    @(negedge clk);
    #1;
    chk("t5_no_done_in_rst", 64'(if_done), 64'd0);
    rsp_delay = 0;
    push(0, 32'h80, 0, 32'h0, 32'hA5A5_0080, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    wait_drain(20, "t5");

    // 6: ready strobes while idle are ignored
    force_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t6_no_if_done", 64'(if_done), 64'd0);
      chk("t6_no_d_done", 64'(d_done), 64'd0);
      chk("t6_no_valid", 64'(mem_valid), 64'd0);
    end
    force_ready = 1'b0;
    @(negedge clk);
    push(0, 32'h44, 0, 32'h0, 32'h0022_1820, 0, 1);
    if_addr = 32'h44;
    if_req = 1'b1;
    wait_drain(20, "t6");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
